// File: rtl/led_pkg.sv
// Shared definitions for the LED run sequencer: mode encodings and the
// position-pointer width helper.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_CHASE    = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_BLINK    = 2'd2,
        MODE_OFF      = 2'd3
    } mode_t;

    // Width of the position pointer: clog2(n), never less than one bit.
    function automatic int pos_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_run_ctrl_if.sv
// Control/status bundle between the board-level driver and the LED sequencer.
interface led_run_ctrl_if #(
    parameter int N_LED = 4
);
    import led_pkg::*;

    logic              En;
    logic [MODE_W-1:0] Mode;
    logic [N_LED-1:0]  LED_Out;
    logic              Step_Pulse;

    modport master (
        output En,
        output Mode,
        input  LED_Out,
        input  Step_Pulse
    );

    modport slave (
        input  En,
        input  Mode,
        output LED_Out,
        output Step_Pulse
    );

endinterface

// File: rtl/led_tick_gen.sv
// Step timer: period counter, step-boundary wrap, duty gate and the
// registered step strobe. Cleared synchronously while En is low.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int CNT_W    = 23,
    parameter int T_STEP   = 20,
    parameter int ON_TICKS = 5
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En,
    output logic wrap,
    output logic gate,
    output logic Step_Pulse
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(T_STEP);

    logic [CNT_W-1:0] cnt;

    // Step boundary: last cycle of the period while running.
    always_comb begin
        wrap = En && (cnt == TERM);
    end

    // Period counter and one-cycle strobe following each boundary.
    always_ff @(posedge CLK) begin
        if (!RSTn || !En) begin
            cnt        <= '0;
            Step_Pulse <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CNT_W'(1);
            Step_Pulse <= wrap;
        end
    end

    // Duty gate; the extreme ON_TICKS values are resolved at elaboration so
    // the counter never has to hold T_STEP+1.
    generate
        if (ON_TICKS == 0) begin : g_gate_never
            // Never lit.
            always_comb begin
                gate = 1'b0;
            end
        end else if (ON_TICKS > T_STEP) begin : g_gate_always
            // Lit for the whole step.
            always_comb begin
                gate = 1'b1;
            end
        end else begin : g_gate_cmp
            localparam logic [CNT_W-1:0] ON_LIM = CNT_W'(ON_TICKS);
            // Lit while the counter is in the first ON_TICKS cycles.
            always_comb begin
                gate = (cnt < ON_LIM);
            end
        end
    endgenerate

endmodule

// File: rtl/led_run_ctrl.sv
// Multi-channel LED sequencer: chase, ping-pong, all-blink and off patterns
// stepped by led_tick_gen. Mode changes take effect only at step boundaries.
module led_run_ctrl
    import led_pkg::*;
#(
    parameter int N_LED    = 4,
    parameter int CNT_W    = 23,
    parameter int T_STEP   = 20,
    parameter int ON_TICKS = 5
) (
    input  logic          CLK,
    input  logic          RSTn,
    led_run_ctrl_if.slave bus
);

    localparam int            PW   = pos_w(N_LED);
    localparam logic [PW-1:0] LAST = PW'(N_LED - 1);

    logic             wrap;
    logic             gate;
    logic             step_pulse;
    mode_t            mode_in;
    mode_t            mode_r;
    logic [PW-1:0]    pos;
    logic             dir_down;
    logic [PW-1:0]    pos_adv;
    logic             dir_adv;
    logic [N_LED-1:0] one_hot;
    logic [N_LED-1:0] led_d;
    logic [N_LED-1:0] led_q;

    led_tick_gen #(
        .CNT_W    (CNT_W),
        .T_STEP   (T_STEP),
        .ON_TICKS (ON_TICKS)
    ) u_tick (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En         (bus.En),
        .wrap       (wrap),
        .gate       (gate),
        .Step_Pulse (step_pulse)
    );

    // Requested mode as the enum type.
    always_comb begin
        mode_in = mode_t'(bus.Mode);
    end

    // Next pointer/direction if the current mode advances at this boundary.
    always_comb begin
        pos_adv = pos;
        dir_adv = dir_down;
        case (mode_r)
            MODE_CHASE: begin
                pos_adv = (pos == LAST) ? '0 : pos + PW'(1);
            end
            MODE_PINGPONG: begin
                if (N_LED > 1) begin
                    if (!dir_down) begin
                        if (pos == LAST) begin
                            dir_adv = 1'b1;
                            pos_adv = pos - PW'(1);
                        end else begin
                            pos_adv = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_adv = 1'b0;
                            pos_adv = PW'(1);
                        end else begin
                            pos_adv = pos - PW'(1);
                        end
                    end
                end
            end
            default: begin
                pos_adv = '0;
                dir_adv = 1'b0;
            end
        endcase
    end

    // Next LED drive from the current counter phase, pointer and mode.
    always_comb begin
        one_hot = N_LED'(1) << pos;
        led_d   = '0;
        if (gate) begin
            case (mode_r)
                MODE_CHASE, MODE_PINGPONG: led_d = one_hot;
                MODE_BLINK:                led_d = '1;
                default:                   led_d = '0;
            endcase
        end
    end

    // Mode, pointer, direction and registered LED outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            mode_r   <= MODE_OFF;
            pos      <= '0;
            dir_down <= 1'b0;
            led_q    <= '0;
        end else if (!bus.En) begin
            mode_r   <= mode_in;
            pos      <= '0;
            dir_down <= 1'b0;
            led_q    <= '0;
        end else begin
            led_q <= led_d;
            if (wrap) begin
                // A mode change restarts the pattern instead of advancing.
                if (mode_in != mode_r) begin
                    mode_r   <= mode_in;
                    pos      <= '0;
                    dir_down <= 1'b0;
                end else begin
                    pos      <= pos_adv;
                    dir_down <= dir_adv;
                end
            end
        end
    end

    assign bus.LED_Out    = led_q;
    assign bus.Step_Pulse = step_pulse;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Directed bench for led_run_ctrl: step table for chase/blink/ping-pong
// sequences, hand sequences for enable gaps and reset, and corner builds.
module tb_led_run_ctrl;
    import led_pkg::*;

    typedef struct {
        logic [3:0] lit;
        int         chg_at;
        mode_t      new_mode;
        logic       chk_pos;
    } step_t;

    logic  CLK;
    logic  RSTn;
    int    total;
    int    bad;
    step_t steps [15];

    led_run_ctrl_if #(.N_LED(4)) bus0 ();
    led_run_ctrl_if #(.N_LED(4)) bus1 ();
    led_run_ctrl_if #(.N_LED(4)) bus2 ();
    led_run_ctrl_if #(.N_LED(1)) bus3 ();

    led_run_ctrl #(.N_LED(4), .CNT_W(23), .T_STEP(20), .ON_TICKS(5))
        u_dut (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
    led_run_ctrl #(.N_LED(4), .CNT_W(23), .T_STEP(20), .ON_TICKS(0))
        u_on0 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));
    led_run_ctrl #(.N_LED(4), .CNT_W(23), .T_STEP(20), .ON_TICKS(21))
        u_on21 (.CLK(CLK), .RSTn(RSTn), .bus(bus2));
    led_run_ctrl #(.N_LED(1), .CNT_W(23), .T_STEP(20), .ON_TICKS(5))
        u_n1 (.CLK(CLK), .RSTn(RSTn), .bus(bus3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full 21-cycle step of the main DUT: 5 lit, 15 dark, then the
    // dark cycle carrying Step_Pulse. Optionally changes Mode mid-step.
    task automatic run_step(input logic [3:0] lit, input int chg_at,
                            input mode_t new_mode, input logic chk_pos);
        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            chk("step_led", 32'(bus0.LED_Out), (i < 5) ? 32'(lit) : 32'h0);
            chk("step_sp", 32'(bus0.Step_Pulse), (i == 20) ? 32'h1 : 32'h0);
            if (chk_pos && i == 0)
                chk("step_pos", 32'(u_dut.pos), 32'h0);
            if (i == chg_at)
                bus0.Mode = new_mode;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        steps[0]  = '{lit: 4'b0001, chg_at: -1, new_mode: MODE_CHASE,    chk_pos: 1'b0};
        steps[1]  = '{lit: 4'b0010, chg_at: -1, new_mode: MODE_CHASE,    chk_pos: 1'b0};
        steps[2]  = '{lit: 4'b0100, chg_at: -1, new_mode: MODE_CHASE,    chk_pos: 1'b0};
        steps[3]  = '{lit: 4'b1000, chg_at: -1, new_mode: MODE_CHASE,    chk_pos: 1'b0};
        steps[4]  = '{lit: 4'b0001, chg_at: -1, new_mode: MODE_CHASE,    chk_pos: 1'b0};
        steps[5]  = '{lit: 4'b0010, chg_at:  9, new_mode: MODE_BLINK,    chk_pos: 1'b0};
        steps[6]  = '{lit: 4'b1111, chg_at:  9, new_mode: MODE_PINGPONG, chk_pos: 1'b1};
        steps[7]  = '{lit: 4'b0001, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b1};
        steps[8]  = '{lit: 4'b0010, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[9]  = '{lit: 4'b0100, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[10] = '{lit: 4'b1000, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[11] = '{lit: 4'b0100, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[12] = '{lit: 4'b0010, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[13] = '{lit: 4'b0001, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};
        steps[14] = '{lit: 4'b0010, chg_at: -1, new_mode: MODE_PINGPONG, chk_pos: 1'b0};

        RSTn      = 1'b0;
        bus0.En   = 1'b0;  bus0.Mode = MODE_CHASE;
        bus1.En   = 1'b0;  bus1.Mode = MODE_CHASE;
        bus2.En   = 1'b0;  bus2.Mode = MODE_BLINK;
        bus3.En   = 1'b0;  bus3.Mode = MODE_PINGPONG;

        repeat (2) @(negedge CLK);
        chk("rst_led", 32'(bus0.LED_Out), 32'h0);
        chk("rst_sp", 32'(bus0.Step_Pulse), 32'h0);
        chk("rst_pos", 32'(u_dut.pos), 32'h0);

        // Release reset; one disabled edge loads the requested mode.
        RSTn = 1'b1;
        @(negedge CLK);
        bus0.En = 1'b1;

        // Chase, chase->blink at cnt=10, blink->ping-pong, ping-pong cycle.
        for (int s = 0; s < 15; s++)
            run_step(steps[s].lit, steps[s].chg_at, steps[s].new_mode, steps[s].chk_pos);

        // Enable dropped for 3 cycles mid-step (ping-pong pointer at 2).
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("gap_pre_led", 32'(bus0.LED_Out), (i < 5) ? 32'h4 : 32'h0);
            chk("gap_pre_sp", 32'(bus0.Step_Pulse), 32'h0);
        end
        bus0.En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("gap_led", 32'(bus0.LED_Out), 32'h0);
            chk("gap_sp", 32'(bus0.Step_Pulse), 32'h0);
        end
        bus0.En = 1'b1;
        run_step(4'b0001, -1, MODE_PINGPONG, 1'b0);
        run_step(4'b0010, -1, MODE_PINGPONG, 1'b0);

        // Reset asserted between edges during a lit cycle.
        bus0.Mode = MODE_CHASE;
        @(negedge CLK);
        chk("prerst_led", 32'(bus0.LED_Out), 32'h4);
        @(posedge CLK);
        #2 RSTn = 1'b0;
        #1 chk("rst_async_led", 32'(bus0.LED_Out), 32'h4);
        @(negedge CLK);
        chk("rst_hold_led", 32'(bus0.LED_Out), 32'h4);
        @(negedge CLK);
        chk("rst2_led", 32'(bus0.LED_Out), 32'h0);
        chk("rst2_sp", 32'(bus0.Step_Pulse), 32'h0);
        chk("rst2_pos", 32'(u_dut.pos), 32'h0);
        RSTn    = 1'b1;
        bus0.En = 1'b0;
        @(negedge CLK);
        chk("rst2_load_led", 32'(bus0.LED_Out), 32'h0);
        bus0.En = 1'b1;
        run_step(4'b0001, -1, MODE_CHASE, 1'b0);
        run_step(4'b0010, -1, MODE_CHASE, 1'b0);

        // Corner builds: ON_TICKS=0, ON_TICKS=T_STEP+1 blink, single LED.
        bus0.En = 1'b0;
        RSTn    = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        bus1.En = 1'b1;
        bus2.En = 1'b1;
        bus3.En = 1'b1;
        for (int k = 0; k < 63; k++) begin
            @(negedge CLK);
            chk("on0_led", 32'(bus1.LED_Out), 32'h0);
            chk("on0_sp", 32'(bus1.Step_Pulse), ((k % 21) == 20) ? 32'h1 : 32'h0);
            chk("on21_led", 32'(bus2.LED_Out), 32'hF);
            chk("on21_sp", 32'(bus2.Step_Pulse), ((k % 21) == 20) ? 32'h1 : 32'h0);
            chk("n1_led", 32'(bus3.LED_Out), ((k % 21) < 5) ? 32'h1 : 32'h0);
            chk("n1_sp", 32'(bus3.Step_Pulse), ((k % 21) == 20) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
